mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised modulo counter, the successor to the fixed 0..0x3E free-running test counter.
- Runtime terminal value, programmable step, up/down direction, wrap or saturate mode, synchronous load and clear, and a registered wrap pulse.
- Used as a general sequencer and index generator, for example for stepping instruction-ROM addresses or driving LED and debug patterns in the RISC-V bring-up design.

Parameters:
- WIDTH, 32, counter, limit, step and load width in bits (minimum 2).
- RESET_VALUE, 0, value of count after reset; must be less than or equal to 2^WIDTH-1.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  advance the count by step this cycle.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- up_down  input  1  1 = count up, 0 = count down.
- step  input  WIDTH  increment/decrement amount; 0 holds the count.
- limit  input  WIDTH  terminal value; the count range is 0..limit inclusive.
- saturate  input  1  1 = saturate at the range ends, 0 = wrap.
- count  output  WIDTH  current count (registered).
- wrap  output  1  one-cycle pulse, registered, asserted the cycle after a wrap or saturation-clip event.
- at_limit  output  1  combinational: count == limit when up_down=1, count == 0 when up_down=0.

Behaviour:
- Reset: reset_n low asynchronously forces count=RESET_VALUE and wrap=0. Reset mid-operation abandons any pending load or step. The first edge after release evaluates normally.
- Priority each edge: clear > load > enable > hold.
- clear: count<=0, wrap<=0.
- load: count<=min(load_value, limit), wrap<=0.
- enable with step=0: count holds, wrap<=0.
- Up count (up_down=1). Compute sum = count + step at WIDTH+1 bits.
  - If sum <= limit: count<=sum, wrap<=0.
  - Else in wrap mode: count<=0, wrap<=1.
  - Else in saturate mode: count<=limit. wrap<=1 only if count != limit before the edge; otherwise wrap<=0 and count holds.
- Down count (up_down=0).
  - If count >= step: count<=count-step, but clipped to limit if the result is greater than limit (this case arises only after limit was lowered at runtime); wrap<=0.
  - Else in wrap mode: count<=limit, wrap<=1.
  - Else in saturate mode: count<=0. wrap<=1 only if count != 0 before the edge.
- Runtime limit change below the current count:
  - The next up step always takes the overflow path (wrap to 0, or saturate to the new limit).
  - No correction happens while enable=0.
- limit=0: up with step>=1 yields count=0 and wrap=1 on every enabled edge in wrap mode; saturate mode holds at 0 with wrap=0.
- Full-scale case: with limit=2^WIDTH-1 and step=1, count runs 0..2^WIDTH-1 then wraps to 0. No intermediate truncation is permitted.
- wrap is high for exactly one cycle per event and is never held. Back-to-back events produce consecutive high cycles.
- Legacy equivalence: WIDTH=32, limit=0x3E, step=1, up, wrap mode, enable=1 reproduces the old 0..0x3E free-run sequence.
- Latency: count and wrap update 1 clock after the qualifying inputs. at_limit follows count combinationally.

Test Plan:
- Reset and free-run: reset_n low, then high; limit=0x3E, step=1, up, wrap, enable=1. Expect count 0,1,…,0x3E,0. wrap is high exactly in the cycle count shows 0 after 0x3E. Repeat for 3 periods.
- Step and wrap: limit=10, step=4, up, start at 0. Expect 4,8,0(wrap=1),4. Repeat with saturate=1: expect 4,8,10(wrap=1),10(wrap=0).
- Down count: load 5, up_down=0, step=2, wrap mode. Expect 3,1,limit(=10, wrap=1). Repeat in saturate mode: expect 3,1,0(wrap=1),0(wrap=0).
- Priority: assert clear, load (load_value=7) and enable together at count=3. Expect count=0. Next cycle with load and enable only: expect 7. A load_value of 20 with limit=10 loads 10.
- Runtime limit drop: count=9 with limit=15; set limit=4, up, step=1. Expect count=0 and wrap=1 on the next enabled edge. With enable=0, count holds at 9 and at_limit=0.
- Async reset mid-count: at count=0x20, pulse reset_n low between clock edges. Expect count=RESET_VALUE and wrap=0 immediately, with no clock needed. Counting resumes from 0 on the first edge after release.

Source files
------------

// File: rtl/mod_counter.sv
// Modulo counter with runtime terminal value, step, direction, wrap/saturate
// mode, synchronous clear/load and a registered one-cycle wrap pulse.
module mod_counter #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_load_clip;
  logic             w_up_fits;
  logic             w_down_fits;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;

  // The sum is one bit wider so a full-scale limit never overflows silently.
  assign w_sum       = {1'b0, r_count} + {1'b0, step};
  assign w_diff      = r_count - step;
  assign w_up_fits   = (w_sum <= {1'b0, limit});
  assign w_down_fits = (r_count >= step);
  assign w_load_clip = (load_value > limit) ? limit : load_value;

  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    if (clear) begin
      w_next_count = '0;
    end else if (load) begin
      w_next_count = w_load_clip;
    end else if (enable && (step != '0)) begin
      if (up_down) begin
        if (w_up_fits) begin
          w_next_count = w_sum[WIDTH-1:0];
        end else if (!saturate) begin
          w_next_count = '0;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = limit;
          w_next_wrap  = (r_count != limit);
        end
      end else begin
        // A limit lowered at runtime can leave the difference above it.
        if (w_down_fits) begin
          w_next_count = (w_diff > limit) ? limit : w_diff;
        end else if (!saturate) begin
          w_next_count = limit;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = '0;
          w_next_wrap  = (r_count != '0);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RESET_VALUE;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign at_limit = up_down ? (r_count == limit) : (r_count == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against {count, wrap, at_limit}.
module tb_mod_counter;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         enable, clear, load, up_down, saturate;
  logic [W-1:0] load_value, step, limit;
  logic [W-1:0] count;
  logic         wrap, at_limit;

  mod_counter #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .up_down    (up_down),
    .step       (step),
    .limit      (limit),
    .saturate   (saturate),
    .count      (count),
    .wrap       (wrap),
    .at_limit   (at_limit)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  int           vec   = 0;
  logic [W+1:0] exp_q[$];
  int           tag_q[$];
  logic [W+1:0] mon_e;
  int           mon_t;

  logic         c_ud;
  logic [W-1:0] c_step, c_lim;
  logic         c_sat;

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      total++;
      if ({count, wrap, at_limit} !== mon_e) begin
        bad++;
        $display("FAIL vec%0d: got count=%0d wrap=%0b at_limit=%0b, want count=%0d wrap=%0b at_limit=%0b",
                 mon_t, count, wrap, at_limit, mon_e[W+1:2], mon_e[1], mon_e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg(input logic ud, input logic [W-1:0] stp, input logic [W-1:0] lim,
                     input logic sat);
    c_ud = ud; c_step = stp; c_lim = lim; c_sat = sat;
  endtask

  task automatic cyc(input logic en, input logic clr, input logic ld,
                     input logic [W-1:0] ldv, input logic [W-1:0] ec, input logic ew);
    @(negedge clock); #1;
    enable = en; clear = clr; load = ld; load_value = ldv;
    up_down = c_ud; step = c_step; limit = c_lim; saturate = c_sat;
    @(posedge clock);
    exp_q.push_back({ec, ew, c_ud ? (ec == c_lim) : (ec == '0)});
    tag_q.push_back(vec);
    vec++;
  endtask

  task automatic en_chk(input logic [W-1:0] ec, input logic ew);
    cyc(1'b1, 1'b0, 1'b0, '0, ec, ew);
  endtask

  task automatic ld_chk(input logic [W-1:0] v, input logic [W-1:0] ec);
    cyc(1'b0, 1'b0, 1'b1, v, ec, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      exp_q.delete(); tag_q.delete();
    end
  endtask

  task automatic chk_direct(input string name, input logic [W-1:0] ac, input logic aw);
    total++;
    if (ac !== '0 || aw !== 1'b0) begin
      bad++;
      $display("FAIL %s: got count=%0d wrap=%0b, want count=0 wrap=0", name, ac, aw);
    end
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic reset_pulse(input string name);
    #1;
    reset_n = 1'b0;
    #1;
    chk_direct(name, count, wrap);
    enable = 1'b0; clear = 1'b0; load = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    enable = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
    up_down = 1'b1; step = 8'd1; limit = 8'h3E; saturate = 1'b0;
    cfg(1'b1, 8'd1, 8'h3E, 1'b0);
    #12;
    chk_direct("reset", count, wrap);
    @(negedge clock); #1;
    reset_n = 1'b1;

    // Legacy free run, three periods of 0..0x3E
    for (int i = 1; i <= 3 * 63; i++)
      en_chk(W'(i % 63), (i % 63) == 0);

    // Step 4 to limit 10, wrap then saturate
    cfg(1'b1, 8'd4, 8'd10, 1'b0);
    en_chk(8'd4, 1'b0); en_chk(8'd8, 1'b0); en_chk(8'd0, 1'b1); en_chk(8'd4, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, 8'd0, 1'b0);
    cfg(1'b1, 8'd4, 8'd10, 1'b1);
    en_chk(8'd4, 1'b0); en_chk(8'd8, 1'b0); en_chk(8'd10, 1'b1); en_chk(8'd10, 1'b0);

    // Down count by 2 from 5
    cfg(1'b0, 8'd2, 8'd10, 1'b0);
    ld_chk(8'd5, 8'd5);
    en_chk(8'd3, 1'b0); en_chk(8'd1, 1'b0); en_chk(8'd10, 1'b1);
    cfg(1'b0, 8'd2, 8'd10, 1'b1);
    ld_chk(8'd5, 8'd5);
    en_chk(8'd3, 1'b0); en_chk(8'd1, 1'b0); en_chk(8'd0, 1'b1); en_chk(8'd0, 1'b0);

    // Priority clear > load > enable, and load clipping
    cfg(1'b1, 8'd1, 8'd10, 1'b0);
    ld_chk(8'd3, 8'd3);
    cyc(1'b1, 1'b1, 1'b1, 8'd7, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'd7, 8'd7, 1'b0);
    ld_chk(8'd20, 8'd10);

    // Runtime limit drop below the count
    cfg(1'b1, 8'd1, 8'd15, 1'b0);
    ld_chk(8'd9, 8'd9);
    cfg(1'b1, 8'd1, 8'd4, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 8'd9, 1'b0);
    en_chk(8'd0, 1'b1);
    cfg(1'b1, 8'd1, 8'd15, 1'b1);
    ld_chk(8'd9, 8'd9);
    cfg(1'b1, 8'd1, 8'd4, 1'b1);
    en_chk(8'd4, 1'b1);
    cfg(1'b0, 8'd1, 8'd15, 1'b0);
    ld_chk(8'd9, 8'd9);
    cfg(1'b0, 8'd1, 8'd4, 1'b0);
    en_chk(8'd4, 1'b0);

    // limit = 0: back-to-back wrap pulses, then saturate holds quietly
    cfg(1'b1, 8'd3, 8'd0, 1'b0);
    ld_chk(8'd5, 8'd0);
    en_chk(8'd0, 1'b1); en_chk(8'd0, 1'b1);
    cfg(1'b1, 8'd3, 8'd0, 1'b1);
    en_chk(8'd0, 1'b0);

    // step = 0 holds
    cfg(1'b1, 8'd0, 8'd10, 1'b0);
    ld_chk(8'd6, 8'd6);
    en_chk(8'd6, 1'b0);

    // Full-scale range
    cfg(1'b1, 8'd1, 8'd255, 1'b0);
    ld_chk(8'd250, 8'd250);
    for (int v = 251; v <= 255; v++) en_chk(W'(v), 1'b0);
    en_chk(8'd0, 1'b1);
    cfg(1'b1, 8'd10, 8'd255, 1'b1);
    ld_chk(8'd250, 8'd250);
    en_chk(8'd255, 1'b1); en_chk(8'd255, 1'b0);
    cfg(1'b0, 8'd1, 8'd255, 1'b0);
    ld_chk(8'd0, 8'd0);
    en_chk(8'd255, 1'b1);

    // Async reset while the wrap pulse is high
    cfg(1'b1, 8'd1, 8'h3E, 1'b0);
    ld_chk(8'h3E, 8'h3E);
    en_chk(8'd0, 1'b1);
    drain();
    reset_pulse("reset_wrap");

    // Async reset mid-count at 0x20, then resume from 0
    for (int i = 1; i <= 32; i++) en_chk(W'(i), 1'b0);
    drain();
    reset_pulse("reset_mid");
    en_chk(8'd1, 1'b0); en_chk(8'd2, 1'b0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit in case the bench itself stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
